// File: rtl/mult_div_if.sv
// ----------------------------------------------------------------------------
// mult_div_if
//   Request/response bundle between the control unit and the multicycle
//   MULT/DIV engine.
//
//   Signals (all sampled on the engine's clk):
//     start     control -> engine  one-cycle request, honoured only when idle
//     op        control -> engine  0 = MULT, 1 = DIV
//     a, b      control -> engine  signed operands (WIDTH bits)
//     busy      engine  -> control iteration in progress
//     done      engine  -> control one-cycle completion pulse
//     div_zero  engine  -> control one-cycle pulse with done on DIV by zero
//     hi, lo    engine  -> control held results (product / remainder,quotient)
//
//   Modports: master = control unit side, slave = engine side.
// ----------------------------------------------------------------------------
interface mult_div_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed MULT/DIV engine serving the control unit's mult/div
//   states. Operands are reduced to magnitudes at start, the result signs are
//   latched, one bit is processed per cycle (shift-add multiply, restoring
//   divide) and the signs are re-applied in a single FINISH cycle that
//   registers HI/LO and pulses done. HI/LO hold between operations and change
//   only on reset or a completed operation.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset (aborts any operation, no done)
//     bus    mult_div_if.slave: start/op/a/b in; busy/done/div_zero/hi/lo out
//
//   Parameters:
//     WIDTH  operand and HI/LO width; iteration count equals WIDTH (>= 2)
//
//   Build option:
//     MULT_DIV_FAST_MULT_EN  when defined, MULT is a single-cycle signed
//                            multiply at the start edge followed by FINISH
//                            (done one edge later). DIV is unaffected.
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    mult_div_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULT   = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MULT: {partial product high, multiplier shifting out / product low}
    // DIV : {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // MULT: multiplicand magnitude; DIV: divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_q, op_d;
    logic               neg_lo_q, neg_lo_d;   // negate product / quotient
    logic               neg_hi_q, neg_hi_d;   // negate remainder (DIV only)
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divz_q, divz_d;

    // Operand magnitudes; -(-2^(W-1)) wraps to 2^(W-1), correct as unsigned.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    assign b_mag = bus.b[WIDTH-1] ? (-bus.b) : bus.b;

    // Shift-add step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right by one, keeping the carry.
    logic [WIDTH:0]     madd;
    logic [2*WIDTH-1:0] mult_next;
    assign madd      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mult_next = {madd, acc_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder, trial
    // subtract. Remainder stays below the divisor (<= 2^(W-1)), so W bits
    // of remainder storage are enough.
    logic [WIDTH:0]     dshift, dsub;
    logic [2*WIDTH-1:0] div_next;
    assign dshift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign dsub     = dshift - {1'b0, opnd_q};
    assign div_next = dsub[WIDTH] ? {dshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {dsub[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    // Sign correction applied in FINISH.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_lo_q ? (-acc_q) : acc_q;
    assign quo_fix  = neg_lo_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULT_DIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a})
                     * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    dz_d  = 1'b0;
                    cnt_d = '0;
                    if (!bus.op) begin
`ifdef MULT_DIV_FAST_MULT_EN
                        // Product is already signed; FINISH must not negate.
                        acc_d    = fast_prod;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = S_FINISH;
`else
                        acc_d    = {{WIDTH{1'b0}}, b_mag};
                        opnd_d   = a_mag;
                        neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_hi_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        state_d  = S_MULT;
`endif
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_hi_d = bus.a[WIDTH-1];
                        if (bus.b == '0) begin
                            dz_d    = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
            end
            S_MULT, S_DIV: begin
                acc_d = (state_q == S_MULT) ? mult_next : div_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    divz_d = 1'b1;            // hi/lo intentionally untouched
                end else if (!op_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    assign bus.busy     = (state_q == S_MULT) || (state_q == S_DIV);
    assign bus.done     = done_q;
    assign bus.div_zero = divz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
